// File: rtl/garage_occupancy_ctrl.sv
// garage_occupancy_ctrl
//
// Multi-lane garage occupancy tracker. Serves LANES entry lanes and LANES
// exit lanes in parallel. Each lane has a two-state gate FSM with a
// down-counting open timer. Entry and exit requests are arbitrated against
// the occupancy at the start of the cycle, lowest lane index first.
// Every output is registered.
//
// Parameters:
//   CAPACITY     number of spaces (1..1023)
//   LANES        entry lanes, and separately exit lanes (1..8)
//   GATE_CYCLES  cycles a gate stays open after a grant (>=1)
//   ALMOST_FULL  occupancy threshold for almost_full (<= CAPACITY)
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   ent_req, ext_req        per-lane level-sampled requests
//   ent_grant, ent_reject   one-cycle pulses per entry lane
//   ext_grant, ext_err      one-cycle pulses per exit lane
//   ent_gate, ext_gate      gate open per lane
//   count                   current occupancy
//   full, almost_full, empty occupancy flags, consistent with count
//
// Optional feature (macro GARAGE_STATS_EN):
//   peak          maximum occupancy since reset
//   reject_total  saturating count of ent_reject pulses
//
// Gate FSM states (one instance per lane and direction):
//   state | meaning
//   IDLE  | gate closed; a request on this lane is eligible
//   OPEN  | gate open; timer counts down, lane eligible again when timer==1
module garage_occupancy_ctrl #(
  parameter int CAPACITY    = 50,
  parameter int LANES       = 2,
  parameter int GATE_CYCLES = 4,
  parameter int ALMOST_FULL = 45,
  localparam int CW         = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] ent_req,
  input  logic [LANES-1:0] ext_req,
  output logic [LANES-1:0] ent_grant,
  output logic [LANES-1:0] ent_reject,
  output logic [LANES-1:0] ext_grant,
  output logic [LANES-1:0] ext_err,
  output logic [LANES-1:0] ent_gate,
  output logic [LANES-1:0] ext_gate,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             almost_full,
  output logic             empty
`ifdef GARAGE_STATS_EN
  ,
  output logic [CW-1:0]    peak,
  output logic [15:0]      reject_total
`endif
);

  localparam int AW = CW + 4;
  localparam int TW = $clog2(GATE_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } gate_state_t;

  gate_state_t      ent_state [LANES];
  gate_state_t      ext_state [LANES];
  logic [TW-1:0]    ent_timer [LANES];
  logic [TW-1:0]    ext_timer [LANES];

  logic [LANES-1:0] ent_free;
  logic [LANES-1:0] ext_free;
  logic [LANES-1:0] ent_acc;
  logic [LANES-1:0] ent_rej;
  logic [LANES-1:0] ext_acc;
  logic [LANES-1:0] ext_rej;
  logic [AW-1:0]    ent_room;
  logic [AW-1:0]    ext_room;
  logic [AW-1:0]    n_ent;
  logic [AW-1:0]    n_ext;
  logic [CW-1:0]    next_count;

  // A gate in its last open cycle (timer==1) closes at the coming edge, so
  // its lane may be granted again at that same edge. This gives one vehicle
  // per GATE_CYCLES cycles on a lane that holds its request.
  always_comb begin
    ent_free = '0;
    ext_free = '0;
    for (int i = 0; i < LANES; i++) begin
      ent_free[i] = (ent_state[i] == IDLE) || (ent_timer[i] == TW'(1));
      ext_free[i] = (ext_state[i] == IDLE) || (ext_timer[i] == TW'(1));
    end
  end

  // Both budgets come from count at the start of the cycle, so a space
  // freed by an exit is not offered to an entry in the same cycle.
  always_comb begin
    ext_room = AW'(count);
    ent_room = AW'(CAPACITY) - AW'(count);
    n_ent    = '0;
    n_ext    = '0;
    ent_acc  = '0;
    ent_rej  = '0;
    ext_acc  = '0;
    ext_rej  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (ext_req[i] && ext_free[i]) begin
        if (n_ext < ext_room) begin
          ext_acc[i] = 1'b1;
          n_ext      = n_ext + AW'(1);
        end else begin
          ext_rej[i] = 1'b1;
        end
      end
      if (ent_req[i] && ent_free[i]) begin
        if (n_ent < ent_room) begin
          ent_acc[i] = 1'b1;
          n_ent      = n_ent + AW'(1);
        end else begin
          ent_rej[i] = 1'b1;
        end
      end
    end
    next_count = CW'(AW'(count) + n_ent - n_ext);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      full        <= 1'b0;
      almost_full <= (ALMOST_FULL == 0);
      empty       <= 1'b1;
      ent_grant   <= '0;
      ent_reject  <= '0;
      ext_grant   <= '0;
      ext_err     <= '0;
      for (int i = 0; i < LANES; i++) begin
        ent_state[i] <= IDLE;
        ext_state[i] <= IDLE;
        ent_timer[i] <= '0;
        ext_timer[i] <= '0;
      end
    end else begin
      count       <= next_count;
      full        <= (next_count == CW'(CAPACITY));
      almost_full <= (next_count >= CW'(ALMOST_FULL));
      empty       <= (next_count == '0);
      ent_grant   <= ent_acc;
      ent_reject  <= ent_rej;
      ext_grant   <= ext_acc;
      ext_err     <= ext_rej;
      for (int i = 0; i < LANES; i++) begin
        if (ent_acc[i]) begin
          ent_state[i] <= OPEN;
          ent_timer[i] <= TW'(GATE_CYCLES);
        end else if (ent_state[i] == OPEN) begin
          if (ent_timer[i] == TW'(1)) ent_state[i] <= IDLE;
          ent_timer[i] <= ent_timer[i] - TW'(1);
        end
        if (ext_acc[i]) begin
          ext_state[i] <= OPEN;
          ext_timer[i] <= TW'(GATE_CYCLES);
        end else if (ext_state[i] == OPEN) begin
          if (ext_timer[i] == TW'(1)) ext_state[i] <= IDLE;
          ext_timer[i] <= ext_timer[i] - TW'(1);
        end
      end
    end
  end

  // The FSM state register is the gate output itself.
  always_comb begin
    ent_gate = '0;
    ext_gate = '0;
    for (int i = 0; i < LANES; i++) begin
      ent_gate[i] = (ent_state[i] == OPEN);
      ext_gate[i] = (ext_state[i] == OPEN);
    end
  end

`ifdef GARAGE_STATS_EN
  logic [16:0] rej_sum;

  // Counted from the same-cycle reject decisions, so reject_total moves
  // together with the ent_reject pulses it counts.
  always_comb begin
    rej_sum = {1'b0, reject_total};
    for (int i = 0; i < LANES; i++) begin
      rej_sum = rej_sum + 17'(ent_rej[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak         <= '0;
      reject_total <= '0;
    end else begin
      if (next_count > peak) peak <= next_count;
      reject_total <= rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
    end
  end
`endif

endmodule
